// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled 8N1 receiver with FIFO write and LSR strobes; UART_RX_PARITY_EN adds an optional parity bit
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic [7:0] dll,
    input  logic [7:0] dlm,
    input  logic       fifo_full,
    input  logic       parity_en,
    input  logic       parity_even,
    output logic [7:0] rx_data_o,
    output logic       rx_we_o,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    output logic       busy_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_bad;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_even;
    assign parity_err_o  = 1'b0;
`endif
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [15:0] div_q, cnt;
    logic [TW-1:0] tc;
    logic [2:0] bi;
    logic [7:0] shreg;
    logic rx_s, tick, armed, bit_end, stop_smp, wrap;
    assign rx_s     = sync[SYNC_STAGES-1];
    assign tick     = div_q != 16'd0 && cnt == div_q - 16'd1;
    assign wrap     = tick || div_q == 16'd0;
    assign bit_end  = tick && tc == LAST;
    assign stop_smp = bit_end && state == STOP;
    // divisor is latched at each wrap so a rewrite never strands the counter past its compare value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '1;
            div_q <= 16'd0;
            cnt   <= 16'd0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rx_i};
            div_q <= wrap ? {dlm, dll} : div_q;
            cnt   <= wrap ? 16'd0 : cnt + 16'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (tick)
            case (state)
                IDLE:   state_n = (armed && !rx_s) ? START : IDLE;
                START:  if (tc == MID) state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:   if (tc == LAST && bi == 3'd7) state_n = parity_en ? PARITY : STOP;
                PARITY: if (tc == LAST) state_n = STOP;
`else
                DATA:   if (tc == LAST && bi == 3'd7) state_n = STOP;
`endif
                STOP:   if (tc == LAST) state_n = IDLE;
                default: state_n = IDLE;
            endcase
    end
    always_comb busy_o = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc    <= '0;
            bi    <= 3'd0;
            shreg <= 8'h00;
            armed <= 1'b0;
        end else begin
            if (tick) tc <= (state_n != state || state == IDLE) ? '0 : tc + TW'(1);
            if (tick && state == START && state_n == DATA) bi <= 3'd0;
            else if (bit_end && state == DATA) begin
                bi    <= bi + 3'd1;
                shreg <= {rx_s, shreg[7:1]};
            end
            // a low stop bit leaves the receiver disarmed until the line is seen high again
            if (stop_smp) armed <= rx_s;
            else if (tick && state == IDLE && rx_s) armed <= 1'b1;
            else if (state != IDLE && state_n == IDLE) armed <= 1'b0;
        end
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (bit_end && state == PARITY) par_bad <= ^{shreg, rx_s, ~parity_even};
            else if (state == START) par_bad <= 1'b0;
            parity_err_o <= stop_smp && par_bad;
        end
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_o   <= 8'h00;
            rx_we_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
            break_o     <= 1'b0;
        end else begin
            rx_we_o     <= stop_smp && !fifo_full;
            overrun_o   <= stop_smp && fifo_full;
            frame_err_o <= stop_smp && !rx_s;
            break_o     <= stop_smp && !rx_s && shreg == 8'h00;
            if (stop_smp && !fifo_full) rx_data_o <= shreg;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx; parity scenario runs when UART_RX_PARITY_EN is defined
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst, rx_i, fifo_full, parity_en, parity_even;
    logic [7:0] dll, dlm, rx_data_o;
    logic rx_we_o, frame_err_o, break_o, overrun_o, parity_err_o, busy_o;
    int vectors = 0, miscompares = 0;
    int n_we = 0, n_fe = 0, n_brk = 0, n_ovr = 0, n_pe = 0, n_pe_we = 0;
    int bit_clks = 16;
    logic [7:0] got[$];

    uart_rx dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .dll(dll), .dlm(dlm),
        .fifo_full(fifo_full), .parity_en(parity_en), .parity_even(parity_even),
        .rx_data_o(rx_data_o), .rx_we_o(rx_we_o), .frame_err_o(frame_err_o),
        .break_o(break_o), .overrun_o(overrun_o), .parity_err_o(parity_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_we_o) begin
            n_we++;
            got.push_back(rx_data_o);
        end
        if (frame_err_o) n_fe++;
        if (break_o) n_brk++;
        if (overrun_o) n_ovr++;
        if (parity_err_o) n_pe++;
        if (parity_err_o && rx_we_o) n_pe_we++;
    end

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_i = 1'b1; dll = 8'd1; dlm = 8'd0;
        fifo_full = 1'b0; parity_en = 1'b0; parity_even = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_data_o, rx_we_o, frame_err_o, break_o, overrun_o, parity_err_o, busy_o} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {rx_data_o, rx_we_o, frame_err_o, break_o, overrun_o, parity_err_o, busy_o});
        end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_basic;
        int we0 = n_we, err0 = n_fe + n_brk + n_ovr + n_pe;
        send_byte(8'hA5, 1'b1);
        idle(8);
        vectors++; if (n_we - we0 !== 1) begin miscompares++; $display("FAIL basic_we got %0d want 1", n_we - we0); end
        vectors++; if (rx_data_o !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", rx_data_o); end
        vectors++; if (n_fe + n_brk + n_ovr + n_pe - err0 !== 0) begin miscompares++; $display("FAIL basic_errs got %0d want 0", n_fe + n_brk + n_ovr + n_pe - err0); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int b = got.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(8);
        vectors++;
        if (got.size() - b !== 2) begin
            miscompares++; $display("FAIL b2b_count got %0d want 2", got.size() - b);
        end else begin
            vectors++; if (got[b] !== 8'h00) begin miscompares++; $display("FAIL b2b_first got %h want 00", got[b]); end
            vectors++; if (got[b+1] !== 8'hFF) begin miscompares++; $display("FAIL b2b_second got %h want ff", got[b+1]); end
        end
    endtask

    task automatic test_glitch;
        int we0 = n_we, fe0 = n_fe;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL glitch_start got %b want 1", busy_o); end
        idle(30);
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL glitch_idle got %b want 0", busy_o); end
        vectors++; if (n_we - we0 + n_fe - fe0 !== 0) begin miscompares++; $display("FAIL glitch_strobes got %0d want 0", n_we - we0 + n_fe - fe0); end
    endtask

    task automatic test_break;
        int we0 = n_we, fe0 = n_fe, brk0 = n_brk;
        rx_i = 1'b0;
        repeat (300) @(negedge clk);
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL break_rearm got %b want 0", busy_o); end
        repeat (20) @(negedge clk);
        idle(60);
        vectors++; if (n_fe - fe0 !== 1) begin miscompares++; $display("FAIL break_fe got %0d want 1", n_fe - fe0); end
        vectors++; if (n_brk - brk0 !== 1) begin miscompares++; $display("FAIL break_brk got %0d want 1", n_brk - brk0); end
        vectors++; if (n_we - we0 !== 1) begin miscompares++; $display("FAIL break_we got %0d want 1", n_we - we0); end
        vectors++; if (rx_data_o !== 8'h00) begin miscompares++; $display("FAIL break_data got %h want 00", rx_data_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL break_busy got %b want 0", busy_o); end
    endtask

    task automatic test_overrun;
        int we0 = n_we, ovr0 = n_ovr;
        fifo_full = 1'b1;
        send_byte(8'h3C, 1'b1);
        idle(4);
        fifo_full = 1'b0;
        vectors++; if (n_ovr - ovr0 !== 1) begin miscompares++; $display("FAIL ovr_pulse got %0d want 1", n_ovr - ovr0); end
        vectors++; if (n_we - we0 !== 0) begin miscompares++; $display("FAIL ovr_we got %0d want 0", n_we - we0); end
        vectors++; if (rx_data_o !== 8'h00) begin miscompares++; $display("FAIL ovr_data got %h want 00", rx_data_o); end
    endtask

    task automatic test_parity;
        int we0 = n_we, pe0 = n_pe, pw0 = n_pe_we;
        parity_en = 1'b1; parity_even = 1'b1;
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i < 3);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(8);
        vectors++; if (n_pe_we - pw0 !== 1) begin miscompares++; $display("FAIL par_err_we got %0d want 1", n_pe_we - pw0); end
        vectors++; if (rx_data_o !== 8'h07) begin miscompares++; $display("FAIL par_data got %h want 07", rx_data_o); end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i < 3);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(8);
        vectors++; if (n_pe - pe0 !== 1) begin miscompares++; $display("FAIL par_good got %0d want 1", n_pe - pe0); end
        vectors++; if (n_we - we0 !== 2) begin miscompares++; $display("FAIL par_we got %0d want 2", n_we - we0); end
`else
        send_byte(8'h5A, 1'b1);
        idle(8);
        vectors++; if (n_we - we0 !== 1) begin miscompares++; $display("FAIL nopar_we got %0d want 1", n_we - we0); end
        vectors++; if (rx_data_o !== 8'h5A) begin miscompares++; $display("FAIL nopar_data got %h want 5a", rx_data_o); end
        vectors++; if (n_pe - pe0 !== 0) begin miscompares++; $display("FAIL nopar_pe got %0d want 0", n_pe - pe0); end
`endif
        parity_en = 1'b0;
    endtask

    task automatic test_divisor;
        int we0 = n_we;
        dll = 8'd0;
        idle(4);
        rx_i = 1'b0;
        repeat (40) @(negedge clk);
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL div0_busy got %b want 0", busy_o); end
        dll = 8'd2;
        bit_clks = 32;
        idle(80);
        send_byte(8'h96, 1'b1);
        idle(16);
        vectors++; if (n_we - we0 !== 1) begin miscompares++; $display("FAIL div2_we got %0d want 1", n_we - we0); end
        vectors++; if (rx_data_o !== 8'h96) begin miscompares++; $display("FAIL div2_data got %h want 96", rx_data_o); end
        dll = 8'd1;
        bit_clks = 16;
        idle(20);
    endtask

    task automatic test_reset_mid_frame;
        int we0 = n_we, fe0 = n_fe;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b want 1", busy_o); end
        rst = 1'b1; rx_i = 1'b1;
        #1;
        vectors++; if ({rx_data_o, busy_o} !== 9'd0) begin miscompares++; $display("FAIL mid_reset got %h want 0", {rx_data_o, busy_o}); end
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        vectors++; if (n_we - we0 + n_fe - fe0 !== 0) begin miscompares++; $display("FAIL mid_strobes got %0d want 0", n_we - we0 + n_fe - fe0); end
        send_byte(8'hC3, 1'b1);
        idle(8);
        vectors++; if (rx_data_o !== 8'hC3 || n_we - we0 !== 1) begin miscompares++; $display("FAIL mid_recover got %h/%0d want c3/1", rx_data_o, n_we - we0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_glitch;
        test_break;
        test_overrun;
        test_parity;
        test_divisor;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
